vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator for the display path. It sits between the pixel FIFO and the DAC/connector logic. It produces pixel coordinates, sync and display-enable signals, and FIFO read strobes for any mode described by its porch/sync parameters. Raster advance is gated by a pixel-clock enable. A mode parameter selects one of two behaviours when the FIFO runs dry in the active region: stall, or free-run with a sticky underrun flag.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- STALL_ON_EMPTY, 1, 1 = stall raster on FIFO empty; 0 = free-run and flag underrun
- CW, 10, coordinate counter width

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  synchronous reset, active-low
- pix_en  in  1  raster advance enable (one pixel per enabled cycle)
- fifo_empty  in  1  pixel FIFO empty
- underrun_clr  in  1  clears underrun
- fifo_rd  out  1  pop one pixel from FIFO
- pixel_x  out  CW  current column, 0..H_TOTAL-1
- pixel_y  out  CW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- disp_en  out  1  high when (pixel_x, pixel_y) is in the visible region
- line_start  out  1  one-cycle pulse on entering x=0
- frame_start  out  1  one-cycle pulse on entering (0,0)
- underrun  out  1  sticky: FIFO was empty when an active pixel was required

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. With defaults these are 800 and 521.
- Elaboration error if 2^CW < H_TOTAL or 2^CW < V_TOTAL.
- Next position (nx, ny):
  - nx = 0 if x = H_TOTAL-1, else x+1.
  - ny advances only when x wraps; ny = 0 if y = V_TOTAL-1, else y+1.
- next_active = (nx < H_ACTIVE) && (ny < V_ACTIVE).
- Advance condition adv:
  - STALL_ON_EMPTY=1: adv = pix_en && !(next_active && fifo_empty). Empty never stalls the raster in blanking.
  - STALL_ON_EMPTY=0: adv = pix_en.
- fifo_rd = adv && next_active && !fifo_empty. This is combinational, issued in the cycle before the new position is presented, so the popped data aligns with that position.
- Underrun:
  - Set when pix_en && next_active && fifo_empty && STALL_ON_EMPTY=0.
  - Cleared by underrun_clr.
  - Set wins over a simultaneous clear.
  - Never set when STALL_ON_EMPTY=1.
- Decodes:
  - hsync = HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
  - vsync uses the same rule on y with V_* and VS_POL.
  - disp_en = (x < H_ACTIVE) && (y < V_ACTIVE).

## Timing
- Registered outputs: pixel_x, pixel_y, hsync, vsync, disp_en, line_start, frame_start, underrun. All are computed from next state and update on the same clk edge as the counters, so sync and disp_en always match the presented coordinates with zero skew.
- Reset (rst_n low at a clk edge):
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1.
  - hsync = !HS_POL, vsync = !VS_POL.
  - disp_en, line_start, frame_start, underrun = 0.
  - fifo_rd = 0 while rst_n is low.
  - Reset mid-frame aborts the frame immediately. The first advance after reset enters (0,0), pops the first pixel and raises frame_start.
- line_start and frame_start:
  - High for exactly one cycle after the advance into x=0 / (0,0).
  - Low on every other cycle, including stalled or pix_en=0 cycles at that position.
- Hold: with adv=0, all coordinates and decodes hold, and fifo_rd=0.
- Frame period with pix_en=1 and no stalls: H_TOTAL*V_TOTAL cycles (416800 default). Exactly H_ACTIVE*V_ACTIVE pops per frame (307200 default).

## Test plan
- Reset, defaults: rst_n=0 for 1 edge -> pixel_x=799, pixel_y=520, hsync=1, vsync=1, disp_en=0, fifo_rd=0, underrun=0.
- Free-run, pix_en=1, fifo_empty=0 -> fifo_rd=1 in first cycle, then (0,0) presented with frame_start=1 and disp_en=1; hsync low for x=656..751 (96 cycles/line); vsync low for y=490..491; 307200 pops and one frame_start per 416800 cycles.
- STALL_ON_EMPTY=1: fifo_empty=1 at x=100, y=10 for 5 cycles -> coordinates hold 5 cycles, fifo_rd=0, underrun=0. Same stimulus at x=700 -> raster keeps advancing.
- STALL_ON_EMPTY=0: fifo_empty=1 for 3 active cycles -> raster advances, fifo_rd=0 on those 3 cycles, underrun=1 and stays 1. underrun_clr=1 with empty=0 -> underrun=0. Clear concurrent with a new underrun -> underrun=1.
- pix_en toggled 1/0 -> raster advances only on enabled cycles; frame_start stays one cycle wide.
- Override H=8/1/2/1, V=4/1/1/1, HS_POL=1, CW=4 -> H_TOTAL=12, hsync high for x=9..10, vsync low for y=5; rst_n low mid-line resets to (11,6) on the next edge.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Pixel FIFO read handshake between the raster timing generator and the
// pixel FIFO that feeds it.
//   fifo_empty : FIFO has no pixel available (driven by the FIFO)
//   fifo_rd    : pop one pixel this cycle (driven by the timing generator)
// Modports:
//   master : timing generator side (consumes pixels)
//   slave  : FIFO side (supplies pixels)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic fifo_empty;
  logic fifo_rd;

  modport master (input fifo_empty, output fifo_rd);
  modport slave  (output fifo_empty, input fifo_rd);
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Walks (pixel_x, pixel_y) over the
// full raster (active + porches + sync), decodes hsync/vsync/disp_en from the
// position, and pops the pixel FIFO one cycle ahead of each visible pixel so
// the FIFO data lines up with the presented coordinate.
// Ports:
//   clk, rst_n    : pixel-domain clock, synchronous active-low reset
//   pix_en        : advance the raster by one pixel on this cycle
//   underrun_clr  : clear the sticky underrun flag
//   fifo          : pixel FIFO handshake (fifo_empty in, fifo_rd out)
//   pixel_x/y     : current column / line
//   hsync, vsync  : sync outputs, active level set by HS_POL / VS_POL
//   disp_en       : current position is visible
//   line_start    : one-cycle pulse after entering x=0
//   frame_start   : one-cycle pulse after entering (0,0)
//   underrun      : sticky, FIFO was empty when a visible pixel was due
// STALL_ON_EMPTY=1 holds the raster while the FIFO cannot supply the next
// visible pixel; STALL_ON_EMPTY=0 keeps the raster running and flags it.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_ACTIVE       = 640,
  parameter int   H_FP           = 16,
  parameter int   H_SYNC         = 96,
  parameter int   H_BP           = 48,
  parameter int   V_ACTIVE       = 480,
  parameter int   V_FP           = 10,
  parameter int   V_SYNC         = 2,
  parameter int   V_BP           = 29,
  parameter logic HS_POL         = 1'b0,
  parameter logic VS_POL         = 1'b0,
  parameter int   STALL_ON_EMPTY = 1,
  parameter int   CW             = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_en,
  input  logic                underrun_clr,
  vga_timing_gen_if.master    fifo,
  output logic [CW-1:0]       pixel_x,
  output logic [CW-1:0]       pixel_y,
  output logic                hsync,
  output logic                vsync,
  output logic                disp_en,
  output logic                line_start,
  output logic                frame_start,
  output logic                underrun
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

  // Counters must be able to hold every raster position.
  if (H_TOTAL > (1 << CW)) begin : g_bad_h
    $error("vga_timing_gen: CW too narrow for H_TOTAL");
  end
  if (V_TOTAL > (1 << CW)) begin : g_bad_v
    $error("vga_timing_gen: CW too narrow for V_TOTAL");
  end

  // Sync level for a position: pol inside [start, start+width), ~pol outside.
  // Positions are compared as int so start+width == 2^CW cannot wrap.
  function automatic logic sync_level(input int pos, input int start,
                                      input int width, input logic pol);
    if ((pos >= start) && (pos < start + width)) begin
      return pol;
    end else begin
      return ~pol;
    end
  endfunction

  logic [CW-1:0] x_r, y_r;
  logic [CW-1:0] nx_s, ny_s;
  logic          next_active_s;
  logic          adv_s;
  logic          underrun_set_s;
  logic          hsync_r, vsync_r, disp_en_r;
  logic          line_start_r, frame_start_r, underrun_r;

  // Next raster position: x wraps at H_TOTAL-1 and carries into y.
  always_comb begin
    nx_s = x_r;
    ny_s = y_r;
    if (x_r == H_LAST) begin
      nx_s = ZERO_C;
      if (y_r == V_LAST) begin
        ny_s = ZERO_C;
      end else begin
        ny_s = y_r + ONE_C;
      end
    end else begin
      nx_s = x_r + ONE_C;
      ny_s = y_r;
    end
  end

  // Advance / pop / underrun decisions for this cycle. Only a visible next
  // pixel needs FIFO data, so an empty FIFO never stalls blanking.
  always_comb begin
    next_active_s  = (int'(nx_s) < H_ACTIVE) && (int'(ny_s) < V_ACTIVE);
    adv_s          = 1'b0;
    underrun_set_s = 1'b0;
    if (STALL_ON_EMPTY != 0) begin
      adv_s = pix_en && !(next_active_s && fifo.fifo_empty);
    end else begin
      adv_s          = pix_en;
      underrun_set_s = pix_en && next_active_s && fifo.fifo_empty;
    end
  end

  // Pop is issued one cycle ahead so the data arrives with its coordinate.
  assign fifo.fifo_rd = rst_n && adv_s && next_active_s && !fifo.fifo_empty;

  // Raster state and decodes, all loaded from the next position together so
  // sync/disp_en never skew against the presented coordinates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r           <= H_LAST;
      y_r           <= V_LAST;
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      disp_en_r     <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      if (adv_s) begin
        x_r           <= nx_s;
        y_r           <= ny_s;
        hsync_r       <= sync_level(int'(nx_s), HS_START, H_SYNC, HS_POL);
        vsync_r       <= sync_level(int'(ny_s), VS_START, V_SYNC, VS_POL);
        disp_en_r     <= next_active_s;
        line_start_r  <= (nx_s == ZERO_C);
        frame_start_r <= (nx_s == ZERO_C) && (ny_s == ZERO_C);
      end else begin
        line_start_r  <= 1'b0;
        frame_start_r <= 1'b0;
      end
      // A new underrun takes priority over a clear in the same cycle.
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

  assign pixel_x     = x_r;
  assign pixel_y     = y_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign disp_en     = disp_en_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen with three instances:
//   A : default 640x480 mode, stall on empty
//   B : default mode, free-run with underrun flag
//   C : small 8x4 mode (H_TOTAL=12, V_TOTAL=7), HS_POL=1, CW=4
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // ---------------- instance A: defaults, STALL_ON_EMPTY=1 ----------------
  logic       rst_n_a, pix_en_a, clr_a;
  logic [9:0] px_a, py_a;
  logic       hs_a, vs_a, de_a, ls_a, fs_a, ur_a;
  vga_timing_gen_if if_a ();

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n_a), .pix_en(pix_en_a), .underrun_clr(clr_a),
    .fifo(if_a.master), .pixel_x(px_a), .pixel_y(py_a), .hsync(hs_a),
    .vsync(vs_a), .disp_en(de_a), .line_start(ls_a), .frame_start(fs_a),
    .underrun(ur_a)
  );

  // ---------------- instance B: defaults, STALL_ON_EMPTY=0 ----------------
  logic       rst_n_b, pix_en_b, clr_b;
  logic [9:0] px_b, py_b;
  logic       hs_b, vs_b, de_b, ls_b, fs_b, ur_b;
  vga_timing_gen_if if_b ();

  vga_timing_gen #(.STALL_ON_EMPTY(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .pix_en(pix_en_b), .underrun_clr(clr_b),
    .fifo(if_b.master), .pixel_x(px_b), .pixel_y(py_b), .hsync(hs_b),
    .vsync(vs_b), .disp_en(de_b), .line_start(ls_b), .frame_start(fs_b),
    .underrun(ur_b)
  );

  // ---------------- instance C: small mode ----------------
  logic       rst_n_c, pix_en_c, clr_c;
  logic [3:0] px_c, py_c;
  logic       hs_c, vs_c, de_c, ls_c, fs_c, ur_c;
  vga_timing_gen_if if_c ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
  ) dut_c (
    .clk(clk), .rst_n(rst_n_c), .pix_en(pix_en_c), .underrun_clr(clr_c),
    .fifo(if_c.master), .pixel_x(px_c), .pixel_y(py_c), .hsync(hs_c),
    .vsync(vs_c), .disp_en(de_c), .line_start(ls_c), .frame_start(fs_c),
    .underrun(ur_c)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; returns 2 time units after it so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance instance A until it presents (xt, yt), within a cycle budget.
  task automatic run_a(input int xt, input int yt, input string tag);
    int n;
    n = 0;
    while (!((int'(px_a) == xt) && (int'(py_a) == yt)) && (n < 20000)) begin
      tick();
      n++;
    end
    check(tag, ((int'(px_a) == xt) && (int'(py_a) == yt)) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int hs_low, hs_first, hs_last;
  int pops, fs_cnt, hs_cnt, vs_cnt, bad;

  initial begin
    rst_n_a = 1'b0; pix_en_a = 1'b0; clr_a = 1'b0; if_a.fifo_empty = 1'b0;
    rst_n_b = 1'b0; pix_en_b = 1'b0; clr_b = 1'b0; if_b.fifo_empty = 1'b0;
    rst_n_c = 1'b0; pix_en_c = 1'b0; clr_c = 1'b0; if_c.fifo_empty = 1'b0;

    // ---- A: reset values ----
    tick();
    check("a_rst_x", px_a, 32'd799);
    check("a_rst_y", py_a, 32'd520);
    check("a_rst_hs", hs_a, 32'd1);
    check("a_rst_vs", vs_a, 32'd1);
    check("a_rst_de", de_a, 32'd0);
    check("a_rst_ur", ur_a, 32'd0);
    check("a_rst_rd", if_a.fifo_rd, 32'd0);

    // ---- A: first advance pops and enters (0,0) ----
    rst_n_a = 1'b1; pix_en_a = 1'b1;
    #1;
    check("a_first_rd", if_a.fifo_rd, 32'd1);
    tick();
    check("a_00_x", px_a, 32'd0);
    check("a_00_y", py_a, 32'd0);
    check("a_00_fs", fs_a, 32'd1);
    check("a_00_ls", ls_a, 32'd1);
    check("a_00_de", de_a, 32'd1);
    check("a_00_hs", hs_a, 32'd1);
    tick();
    check("a_01_x", px_a, 32'd1);
    check("a_01_fs", fs_a, 32'd0);

    // ---- A: hsync window over the rest of line 0 ----
    hs_low = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 799; i++) begin
      tick();
      if (hs_a === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(px_a);
        hs_last = int'(px_a);
      end
    end
    check("a_hs_width", hs_low, 32'd96);
    check("a_hs_first", hs_first, 32'd656);
    check("a_hs_last", hs_last, 32'd751);
    check("a_wrap_x", px_a, 32'd0);
    check("a_wrap_y", py_a, 32'd1);
    check("a_wrap_ls", ls_a, 32'd1);
    check("a_wrap_fs", fs_a, 32'd0);

    // ---- A: empty in active region stalls ----
    run_a(100, 10, "a_reach_100_10");
    if_a.fifo_empty = 1'b1;
    #1;
    check("a_stall_rd0", if_a.fifo_rd, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("a_stall_x", px_a, 32'd100);
      check("a_stall_y", py_a, 32'd10);
      check("a_stall_rd", if_a.fifo_rd, 32'd0);
    end
    check("a_stall_ur", ur_a, 32'd0);
    if_a.fifo_empty = 1'b0;
    #1;
    check("a_resume_rd", if_a.fifo_rd, 32'd1);
    tick();
    check("a_resume_x", px_a, 32'd101);

    // ---- A: empty in blanking does not stall ----
    run_a(700, 10, "a_reach_700_10");
    if_a.fifo_empty = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("a_blank_x", px_a, 32'd705);
    check("a_blank_rd", if_a.fifo_rd, 32'd0);
    check("a_blank_ur", ur_a, 32'd0);
    if_a.fifo_empty = 1'b0;

    // ---- A: pix_en gating after a fresh reset ----
    rst_n_a = 1'b0;
    tick();
    check("a_rst2_x", px_a, 32'd799);
    rst_n_a = 1'b1;
    tick();
    check("a_pe_fs1", fs_a, 32'd1);
    pix_en_a = 1'b0;
    #1;
    check("a_pe_hold_rd", if_a.fifo_rd, 32'd0);
    tick();
    check("a_pe_hold_x", px_a, 32'd0);
    check("a_pe_fs0", fs_a, 32'd0);
    check("a_pe_ls0", ls_a, 32'd0);
    check("a_pe_de", de_a, 32'd1);
    pix_en_a = 1'b1;
    tick();
    check("a_pe_adv_x", px_a, 32'd1);
    pix_en_a = 1'b0;
    tick();
    check("a_pe_hold2_x", px_a, 32'd1);

    // ---- B: free-run with underrun ----
    rst_n_b = 1'b1; pix_en_b = 1'b1;
    tick();
    check("b_00_x", px_b, 32'd0);
    tick();
    check("b_01_x", px_b, 32'd1);
    if_b.fifo_empty = 1'b1;
    #1;
    check("b_ur_rd0", if_b.fifo_rd, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_ur_x", px_b, 32'(i + 2));
      check("b_ur_rd", if_b.fifo_rd, 32'd0);
      check("b_ur_set", ur_b, 32'd1);
    end
    if_b.fifo_empty = 1'b0;
    tick();
    check("b_ur_sticky", ur_b, 32'd1);
    check("b_ur_x5", px_b, 32'd5);
    clr_b = 1'b1;
    tick();
    check("b_ur_clr", ur_b, 32'd0);
    if_b.fifo_empty = 1'b1;
    tick();
    check("b_ur_set_wins", ur_b, 32'd1);
    clr_b = 1'b0; if_b.fifo_empty = 1'b0;

    // ---- C: reset values, small mode ----
    check("c_rst_x", px_c, 32'd11);
    check("c_rst_y", py_c, 32'd6);
    check("c_rst_hs", hs_c, 32'd0);
    check("c_rst_vs", vs_c, 32'd1);

    // ---- C: one full frame ----
    rst_n_c = 1'b1; pix_en_c = 1'b1;
    #1;
    pops = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; bad = 0;
    for (int i = 0; i < 84; i++) begin
      if (if_c.fifo_rd === 1'b1) pops++;
      tick();
      if (fs_c === 1'b1) fs_cnt++;
      if (hs_c === 1'b1) begin
        hs_cnt++;
        if (!((px_c == 4'd9) || (px_c == 4'd10))) bad++;
      end
      if (vs_c === 1'b0) begin
        vs_cnt++;
        if (py_c != 4'd5) bad++;
      end
      if (de_c !== ((px_c < 4'd8) && (py_c < 4'd4))) bad++;
    end
    check("c_pops", pops, 32'd32);
    check("c_frame_starts", fs_cnt, 32'd1);
    check("c_hs_cycles", hs_cnt, 32'd14);
    check("c_vs_cycles", vs_cnt, 32'd12);
    check("c_decode_bad", bad, 32'd0);
    check("c_frame_x", px_c, 32'd11);
    check("c_frame_y", py_c, 32'd6);

    // ---- C: reset mid-line ----
    for (int i = 0; i < 3; i++) tick();
    check("c_mid_x", px_c, 32'd2);
    rst_n_c = 1'b0;
    #1;
    check("c_mid_rst_rd", if_c.fifo_rd, 32'd0);
    tick();
    check("c_mid_rst_x", px_c, 32'd11);
    check("c_mid_rst_y", py_c, 32'd6);
    check("c_mid_rst_hs", hs_c, 32'd0);
    check("c_mid_rst_de", de_c, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
